// File: rtl/rr_stream_merge_2.sv
// rr_stream_merge_2: two-input stream merger with round-robin arbitration.
//
// Each client writes into a private DEPTH-entry FIFO. A two-way round-robin
// arbiter picks a non-empty FIFO whenever the registered output stage can be
// loaded, and the chosen head is popped into the output register.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in0_valid/ready/data client 0 input stream
//   in1_valid/ready/data client 1 input stream
//   out_valid/ready      registered output handshake
//   out_data, out_src    forwarded payload and its source index
//   level0, level1       FIFO occupancy per client (0..DEPTH)
module rr_stream_merge_2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in0_valid,
  output logic                     in0_ready,
  input  logic [WIDTH-1:0]         in0_data,
  input  logic                     in1_valid,
  output logic                     in1_ready,
  input  logic [WIDTH-1:0]         in1_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_src,
  output logic [$clog2(DEPTH):0]   level0,
  output logic [$clog2(DEPTH):0]   level1
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [PtrW-1:0]  wptr_q [2];
  logic [PtrW-1:0]  rptr_q [2];
  logic [LvlW-1:0]  lvl_q  [2];
  logic [LvlW-1:0]  lvl_d  [2];

  logic             in_valid [2];
  logic [WIDTH-1:0] in_data  [2];
  logic             in_ready [2];
  logic             push     [2];
  logic             pop      [2];
  logic             req      [2];

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_src_q;
  logic             last_q;

  logic             load;
  logic             any_req;
  logic             grant;
  logic [WIDTH-1:0] head;

  assign in_valid[0] = in0_valid;
  assign in_valid[1] = in1_valid;
  assign in_data[0]  = in0_data;
  assign in_data[1]  = in1_data;

  // Ready depends only on registered occupancy and reset, so a full FIFO
  // refuses a push even in a cycle where it is being popped.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_ready[i] = (lvl_q[i] != LvlW'(DEPTH)) & ~rst;
      push[i]     = in_valid[i] & in_ready[i];
      req[i]      = (lvl_q[i] != '0);
    end
  end

  // Arbitration: a lone request wins; on contention the source not granted
  // last time wins.
  always_comb begin
    load    = ~out_valid_q | out_ready;
    any_req = req[0] | req[1];
    grant   = req[1] & (~req[0] | ~last_q);
    pop[0]  = load & req[0] & ~grant;
    pop[1]  = load & req[1] & grant;
    head    = grant ? mem_q[1][rptr_q[1]] : mem_q[0][rptr_q[0]];
    for (int i = 0; i < 2; i++) begin
      lvl_d[i] = lvl_q[i] + LvlW'(push[i]) - LvlW'(pop[i]);
    end
  end

  // Storage needs no reset: nothing is read from an empty FIFO.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        lvl_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + PtrW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + PtrW'(1);
        lvl_q[i] <= lvl_d[i];
      end
    end
  end

  // last resets to 1 so the first contended grant goes to source 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      last_q      <= 1'b1;
    end else if (load) begin
      if (any_req) begin
        out_valid_q <= 1'b1;
        out_data_q  <= head;
        out_src_q   <= grant;
        last_q      <= grant;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in0_ready = in_ready[0];
  assign in1_ready = in_ready[1];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign level0    = lvl_q[0];
  assign level1    = lvl_q[1];

endmodule

// File: tb/tb_rr_stream_merge_2.sv
// Directed self-checking bench for rr_stream_merge_2 (WIDTH=8, DEPTH=4).
module tb_rr_stream_merge_2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid, in1_valid;
  logic       in0_ready, in1_ready;
  logic [7:0] in0_data, in1_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_src;
  logic [2:0] level0, level1;

  int n_checks = 0;
  int n_fails  = 0;

  rr_stream_merge_2 #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .level0    (level0),
    .level1    (level1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] obs_d;
    logic       obs_s, do_push, do_acc;
    int         sent, got;

    // Reset with valids and out_ready asserted: nothing may be written.
    rst       = 1'b1;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 8'h5a;
    in1_data  = 8'ha5;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out_data", 32'(out_data), 32'(0));
      check("rst_in0_ready", 32'(in0_ready), 32'(0));
      check("rst_in1_ready", 32'(in1_ready), 32'(0));
    end
    rst       = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    #1;
    check("rst_level0", 32'(level0), 32'(0));
    check("rst_level1", 32'(level1), 32'(0));
    check("rel_in0_ready", 32'(in0_ready), 32'(1));
    check("rel_in1_ready", 32'(in1_ready), 32'(1));

    // Single source: 0x11,0x22,0x33 on in0, out_ready high.
    in0_valid = 1'b1; in0_data = 8'h11; step();
    check("ss_bubble", 32'(out_valid), 32'(0));
    check("ss_level0", 32'(level0), 32'(1));
    in0_data = 8'h22; step();
    check("ss_v0", 32'(out_valid), 32'(1));
    check("ss_d0", 32'(out_data), 32'(8'h11));
    check("ss_s0", 32'(out_src), 32'(0));
    in0_data = 8'h33; step();
    check("ss_d1", 32'(out_data), 32'(8'h22));
    in0_valid = 1'b0; step();
    check("ss_d2", 32'(out_data), 32'(8'h33));
    check("ss_s2", 32'(out_src), 32'(0));
    step();
    check("ss_drain", 32'(out_valid), 32'(0));

    // Contention: fresh reset so last=1, preload with output stalled.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in0_valid = 1'b1; in0_data = 8'(8'ha0 + k);
      in1_valid = 1'b1; in1_data = 8'(8'hb0 + k);
      step();
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    // A0 already sits in the output register; FIFO0 holds A1..A3.
    check("ct_level0", 32'(level0), 32'(3));
    check("ct_level1", 32'(level1), 32'(4));
    check("ct_in1_full", 32'(in1_ready), 32'(0));
    check("ct_first_data", 32'(out_data), 32'(8'ha0));
    check("ct_first_src", 32'(out_src), 32'(0));
    out_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      step();
      check("ct_valid", 32'(out_valid), 32'(1));
      check("ct_data", 32'(out_data), 32'(((k % 2) ? 8'hb0 : 8'ha0) + k / 2));
      check("ct_src", 32'(out_src), 32'(k % 2));
    end
    step();
    check("ct_idle", 32'(out_valid), 32'(0));

    // Full/backpressure on in1: C0 lands in the output, C1..C4 fill the FIFO.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("fb_ready_before", 32'(in1_ready), 32'(1));
      in1_valid = 1'b1; in1_data = 8'(8'hc0 + k);
      step();
      if (k > 0) check("fb_hold", 32'(out_data), 32'(8'hc0));
    end
    check("fb_level1", 32'(level1), 32'(4));
    check("fb_ready_low", 32'(in1_ready), 32'(0));
    in1_data = 8'hc5; step();
    check("fb_refused_level", 32'(level1), 32'(4));
    check("fb_hold_last", 32'(out_data), 32'(8'hc0));
    in1_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      check("fb_data", 32'(out_data), 32'(8'hc0 + k));
      check("fb_src", 32'(out_src), 32'(1));
    end
    step();
    check("fb_no_extra", 32'(out_valid), 32'(0));

    // Wrap: 20 words on in0 with out_ready toggling, scoreboarded.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      out_ready = (cyc % 2 == 0);
      in0_valid = (sent < 20);
      in0_data  = 8'(32'h40 + sent);
      #1;
      do_push = in0_valid & in0_ready;
      do_acc  = out_valid & out_ready;
      obs_d   = out_data;
      obs_s   = out_src;
      if (do_push) exp_q.push_back(in0_data);
      step();
      if (do_push) sent++;
      if (do_acc) begin
        if (exp_q.size() == 0) check("wrap_spurious", 32'(1), 32'(0));
        else check("wrap_data", 32'(obs_d), 32'(exp_q.pop_front()));
        check("wrap_src", 32'(obs_s), 32'(0));
        got++;
      end
      check("wrap_level_le4", 32'(level0 <= 3'd4), 32'(1));
    end
    check("wrap_sent", 32'(sent), 32'(20));
    check("wrap_got", 32'(got), 32'(20));
    in0_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("wrap_idle", 32'(out_valid), 32'(0));

    // Reset mid-stream: last is 0 here, so E0 takes the output first.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in0_valid = (k < 3); in0_data = 8'(8'hd0 + k);
      in1_valid = 1'b1;    in1_data = 8'(8'he0 + k);
      step();
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    check("mr_pre_valid", 32'(out_valid), 32'(1));
    check("mr_pre_data", 32'(out_data), 32'(8'he0));
    check("mr_pre_level0", 32'(level0), 32'(3));
    check("mr_pre_level1", 32'(level1), 32'(3));
    rst = 1'b1;
    step();
    check("mr_valid", 32'(out_valid), 32'(0));
    check("mr_level0", 32'(level0), 32'(0));
    check("mr_level1", 32'(level1), 32'(0));
    check("mr_in_ready", 32'(in0_ready), 32'(0));
    rst = 1'b0;
    in0_valid = 1'b1; in0_data = 8'hf0;
    in1_valid = 1'b1; in1_data = 8'hf1;
    step();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    step();
    check("mr_grant_src", 32'(out_src), 32'(0));
    check("mr_grant_data", 32'(out_data), 32'(8'hf0));
    out_ready = 1'b1;
    step();
    check("mr_second_src", 32'(out_src), 32'(1));
    check("mr_second_data", 32'(out_data), 32'(8'hf1));
    step();
    check("mr_idle", 32'(out_valid), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
